bus_demux32x4: RTL and testbench

- Registered one-to-four bus distributor: a single CPU-side bus master is routed to one of four slave ports.
- The target port is selected by the top address bits.
- One transaction is tracked until the selected slave acks; the read data is then returned to the master.
- It is the routing counterpart to the 32-bit selection muxes and sits between the CPU bus and the memory/peripheral slaves.

---
 rtl/bus_demux32x4_pkg.sv | 30 +++
 rtl/mux32x4.sv | 24 ++
 rtl/bus_demux32x4.sv | 135 +++++++++++++
 tb/tb_bus_demux32x4.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_demux32x4_pkg.sv
// Shared types and constants for the bus_demux32x4 distributor.
package bus_demux32x4_pkg;

    localparam int unsigned NUM_PORTS              = 4;
    localparam int unsigned IDX_W                  = 2;
    localparam int unsigned DATA_W                 = 32;
    localparam int unsigned SEL_W                  = 4;
    localparam int unsigned CNT_W                  = 16;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Request payload broadcast to every slave port.
    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  sel;
    } bus_req_t;

    // One-hot strobe for a given port index.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [IDX_W-1:0] idx);
        return NUM_PORTS'(1) << idx;
    endfunction

endpackage

// File: rtl/mux32x4.sv
// Four-input 32-bit selection mux used for read-data return.
module mux32x4
    import bus_demux32x4_pkg::*;
(
    input  logic [IDX_W-1:0]  sel,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic [DATA_W-1:0] d3,
    output logic [DATA_W-1:0] y_c
);

    // Pick one of the four inputs.
    always_comb begin
        y_c = d0;
        case (sel)
            2'd1:    y_c = d1;
            2'd2:    y_c = d2;
            2'd3:    y_c = d3;
            default: y_c = d0;
        endcase
    end

endmodule

// File: rtl/bus_demux32x4.sv
// Registered one-to-four bus distributor: routes one master transaction to the
// slave chosen by I_addr[SEL_LO+1:SEL_LO] and returns that slave's read data.
// Optional ack timeout enabled by defining BUS_DEMUX32X4_TIMEOUT_EN.
module bus_demux32x4
    import bus_demux32x4_pkg::*;
#(
    parameter int unsigned SEL_LO = 30
`ifdef BUS_DEMUX32X4_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
    input  logic                 I_clk,
    input  logic                 I_reset,
    input  logic                 I_stb,
    input  logic                 I_we,
    input  logic [DATA_W-1:0]    I_addr,
    input  logic [DATA_W-1:0]    I_data,
    input  logic [SEL_W-1:0]     I_sel,
    output logic [DATA_W-1:0]    O_data,
    output logic                 O_ack,
    output logic                 O_err,
    output logic [NUM_PORTS-1:0] O_slv_stb,
    output logic                 O_slv_we,
    output logic [DATA_W-1:0]    O_slv_addr,
    output logic [DATA_W-1:0]    O_slv_data,
    output logic [SEL_W-1:0]     O_slv_sel,
    input  logic [NUM_PORTS-1:0] I_slv_ack,
    input  logic [DATA_W-1:0]    I_slv_data0,
    input  logic [DATA_W-1:0]    I_slv_data1,
    input  logic [DATA_W-1:0]    I_slv_data2,
    input  logic [DATA_W-1:0]    I_slv_data3
);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    bus_req_t          req;
    logic [DATA_W-1:0] rd_data_c;

    assign O_slv_we   = req.we;
    assign O_slv_addr = req.addr;
    assign O_slv_data = req.data;
    assign O_slv_sel  = req.sel;

`ifdef BUS_DEMUX32X4_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    logic [CNT_W-1:0] count;
    logic             err;
    assign O_err = err;
`else
    assign O_err = 1'b0;
`endif

    // Read data from the currently selected slave.
    mux32x4 u_rd_mux (
        .sel (idx),
        .d0  (I_slv_data0),
        .d1  (I_slv_data1),
        .d2  (I_slv_data2),
        .d3  (I_slv_data3),
        .y_c (rd_data_c)
    );

    // Transaction FSM with registered outputs.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state     <= IDLE;
            idx       <= '0;
            req       <= '0;
            O_slv_stb <= '0;
            O_data    <= '0;
            O_ack     <= 1'b0;
`ifdef BUS_DEMUX32X4_TIMEOUT_EN
            count     <= '0;
            err       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    O_ack <= 1'b0;
                    if (I_stb) begin
                        idx       <= I_addr[SEL_LO+1:SEL_LO];
                        req.we    <= I_we;
                        req.addr  <= I_addr;
                        req.data  <= I_data;
                        req.sel   <= I_sel;
                        O_slv_stb <= port_onehot(I_addr[SEL_LO+1:SEL_LO]);
`ifdef BUS_DEMUX32X4_TIMEOUT_EN
                        count     <= '0;
`endif
                        state     <= ACTIVE;
                    end else begin
                        O_slv_stb <= '0;
                    end
                end
                ACTIVE: begin
                    if (I_slv_ack[idx]) begin
                        O_data    <= rd_data_c;
                        O_ack     <= 1'b1;
                        O_slv_stb <= '0;
`ifdef BUS_DEMUX32X4_TIMEOUT_EN
                        err       <= 1'b0;
`endif
                        state     <= DONE;
                    end
`ifdef BUS_DEMUX32X4_TIMEOUT_EN
                    else if (count == CNT_LAST) begin
                        O_data    <= '0;
                        O_ack     <= 1'b1;
                        err       <= 1'b1;
                        O_slv_stb <= '0;
                        state     <= DONE;
                    end else if (count != CNT_MAX) begin
                        count     <= count + CNT_W'(1);
                    end
`endif
                end
                DONE: begin
                    O_ack <= 1'b0;
`ifdef BUS_DEMUX32X4_TIMEOUT_EN
                    err   <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: begin
                    O_ack     <= 1'b0;
                    O_slv_stb <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_demux32x4.sv
// Self-checking bench for bus_demux32x4: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_bus_demux32x4;

    logic        I_clk;
    logic        I_reset;
    logic        I_stb;
    logic        I_we;
    logic [31:0] I_addr;
    logic [31:0] I_data;
    logic [3:0]  I_sel;
    logic [31:0] O_data;
    logic        O_ack;
    logic        O_err;
    logic [3:0]  O_slv_stb;
    logic        O_slv_we;
    logic [31:0] O_slv_addr;
    logic [31:0] O_slv_data;
    logic [3:0]  O_slv_sel;
    logic [3:0]  I_slv_ack;
    logic [31:0] sd [4];

    int vectors = 0;
    int errors  = 0;

    bus_demux32x4 #(
        .SEL_LO(30)
`ifdef BUS_DEMUX32X4_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .I_clk       (I_clk),
        .I_reset     (I_reset),
        .I_stb       (I_stb),
        .I_we        (I_we),
        .I_addr      (I_addr),
        .I_data      (I_data),
        .I_sel       (I_sel),
        .O_data      (O_data),
        .O_ack       (O_ack),
        .O_err       (O_err),
        .O_slv_stb   (O_slv_stb),
        .O_slv_we    (O_slv_we),
        .O_slv_addr  (O_slv_addr),
        .O_slv_data  (O_slv_data),
        .O_slv_sel   (O_slv_sel),
        .I_slv_ack   (I_slv_ack),
        .I_slv_data0 (sd[0]),
        .I_slv_data1 (sd[1]),
        .I_slv_data2 (sd[2]),
        .I_slv_data3 (sd[3])
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    task automatic step();
        @(posedge I_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] a, wd, last_data, exp_d;
        logic [3:0]  bs, exp_stb;
        logic        we;
        int          port, dly;

        I_reset = 1'b1; I_stb = 0; I_we = 0; I_addr = 0; I_data = 0; I_sel = 0;
        I_slv_ack = 0;
        for (int i = 0; i < 4; i++) sd[i] = 32'h0;
        last_data = 32'h0;

        // Reset values
        step(); step();
        chk("rst_stb", 32'(O_slv_stb), 32'h0);
        chk("rst_ack", 32'(O_ack), 32'h0);
        chk("rst_err", 32'(O_err), 32'h0);
        chk("rst_data", O_data, 32'h0);
        chk("rst_addr", O_slv_addr, 32'h0);
        I_reset = 1'b0;
        step();

        // Read routing to slave 2
        I_stb = 1; I_we = 0; I_addr = 32'h8000_0010; I_sel = 4'hF;
        step();
        I_stb = 0;
        chk("rd_stb", 32'(O_slv_stb), 32'h4);
        chk("rd_addr", O_slv_addr, 32'h8000_0010);
        chk("rd_ack_early", 32'(O_ack), 32'h0);
        I_slv_ack = 4'b0100; sd[2] = 32'hDEAD_BEEF;
        step();
        chk("rd_ack", 32'(O_ack), 32'h1);
        chk("rd_data", O_data, 32'hDEAD_BEEF);
        chk("rd_err", 32'(O_err), 32'h0);
        chk("rd_stb_drop", 32'(O_slv_stb), 32'h0);
        step();
        chk("rd_ack_done", 32'(O_ack), 32'h0);
        I_slv_ack = 0;
        step();
        chk("rd_ack_idle", 32'(O_ack), 32'h0);
        chk("rd_data_hold", O_data, 32'hDEAD_BEEF);

        // Write broadcast to slave 3 with five wait cycles
        I_stb = 1; I_we = 1; I_addr = 32'hC000_0004; I_data = 32'h1234_5678; I_sel = 4'b0011;
        step();
        chk("wr_stb", 32'(O_slv_stb), 32'h8);
        chk("wr_we", 32'(O_slv_we), 32'h1);
        chk("wr_addr", O_slv_addr, 32'hC000_0004);
        chk("wr_wdata", O_slv_data, 32'h1234_5678);
        chk("wr_sel", 32'(O_slv_sel), 32'h3);
        I_we = 0; I_addr = 32'h0000_0000; I_data = 32'hFFFF_FFFF; I_sel = 4'hC;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("wr_hold_stb", 32'(O_slv_stb), 32'h8);
            chk("wr_hold_addr", O_slv_addr, 32'hC000_0004);
            chk("wr_hold_wdata", O_slv_data, 32'h1234_5678);
            chk("wr_hold_sel", 32'(O_slv_sel), 32'h3);
            chk("wr_hold_we", 32'(O_slv_we), 32'h1);
            chk("wr_hold_ack", 32'(O_ack), 32'h0);
        end
        I_stb = 0;
        I_slv_ack = 4'b1000; sd[3] = 32'h0BAD_F00D;
        step();
        chk("wr_ack", 32'(O_ack), 32'h1);
        chk("wr_rdata", O_data, 32'h0BAD_F00D);
        I_slv_ack = 0;
        step();
        chk("wr_ack_done", 32'(O_ack), 32'h0);

        // Acks from a non-selected port are ignored
        I_stb = 1; I_addr = 32'h0000_0100;
        step();
        I_stb = 0;
        chk("wp_stb", 32'(O_slv_stb), 32'h1);
        I_slv_ack = 4'b0010; sd[0] = 32'hA5A5_0001; sd[1] = 32'h5A5A_0002;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wp_noack", 32'(O_ack), 32'h0);
            chk("wp_stb_hold", 32'(O_slv_stb), 32'h1);
        end
        I_slv_ack = 4'b0001;
        step();
        chk("wp_ack", 32'(O_ack), 32'h1);
        chk("wp_data", O_data, 32'hA5A5_0001);
        I_slv_ack = 0;
        step();

        // Back-to-back with strobe held high through DONE
        I_stb = 1; I_addr = 32'h4000_0000;
        step();
        chk("b2b_stb1", 32'(O_slv_stb), 32'h2);
        I_slv_ack = 4'b0010; sd[1] = 32'h1111_1111;
        step();
        chk("b2b_ack1", 32'(O_ack), 32'h1);
        chk("b2b_data1", O_data, 32'h1111_1111);
        I_slv_ack = 0; I_addr = 32'hC000_0000;
        step();
        chk("b2b_done_ack", 32'(O_ack), 32'h0);
        chk("b2b_done_stb", 32'(O_slv_stb), 32'h0);
        step();
        chk("b2b_stb2", 32'(O_slv_stb), 32'h8);
        chk("b2b_addr2", O_slv_addr, 32'hC000_0000);
        chk("b2b_gap_ack", 32'(O_ack), 32'h0);
        I_stb = 0; I_slv_ack = 4'b1000; sd[3] = 32'h2222_2222;
        step();
        chk("b2b_ack2", 32'(O_ack), 32'h1);
        chk("b2b_data2", O_data, 32'h2222_2222);
        I_slv_ack = 0;
        step();
        chk("b2b_ack2_end", 32'(O_ack), 32'h0);

        // Reset in the middle of a transaction
        I_stb = 1; I_addr = 32'h4000_0000;
        step();
        I_stb = 0;
        chk("mr_stb", 32'(O_slv_stb), 32'h2);
        #2 I_reset = 1'b1;
        #1;
        chk("mr_stb_async", 32'(O_slv_stb), 32'h0);
        chk("mr_data_async", O_data, 32'h0);
        step();
        I_reset = 1'b0;
        I_slv_ack = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mr_noack", 32'(O_ack), 32'h0);
            chk("mr_idle_stb", 32'(O_slv_stb), 32'h0);
        end
        I_slv_ack = 0;
        last_data = 32'h0;

        // Randomized transactions against a transaction-level model
        for (int t = 0; t < 40; t++) begin
            a = $urandom; we = 1'($urandom); wd = $urandom; bs = 4'($urandom);
            dly = $urandom_range(0, 5);
            port = int'(a / 32'h4000_0000);
            exp_stb = 4'(1 << port);
            I_stb = 1; I_we = we; I_addr = a; I_data = wd; I_sel = bs; I_slv_ack = 0;
            step();
            chk("rnd_stb", 32'(O_slv_stb), 32'(exp_stb));
            chk("rnd_addr", O_slv_addr, a);
            chk("rnd_wdata", O_slv_data, wd);
            chk("rnd_we", 32'(O_slv_we), 32'(we));
            chk("rnd_sel", 32'(O_slv_sel), 32'(bs));
            chk("rnd_hold_data", O_data, last_data);
            for (int d = 0; d < dly; d++) begin
                I_stb = 1'($urandom); I_addr = $urandom;
                I_slv_ack = 4'($urandom) & ~exp_stb;
                for (int i = 0; i < 4; i++) sd[i] = $urandom;
                step();
                chk("rnd_wait_ack", 32'(O_ack), 32'h0);
                chk("rnd_wait_stb", 32'(O_slv_stb), 32'(exp_stb));
                chk("rnd_wait_addr", O_slv_addr, a);
            end
            I_stb = 0;
            I_slv_ack = 4'($urandom) | exp_stb;
            for (int i = 0; i < 4; i++) sd[i] = $urandom;
            exp_d = sd[port];
            step();
            chk("rnd_ack", 32'(O_ack), 32'h1);
            chk("rnd_err", 32'(O_err), 32'h0);
            chk("rnd_data", O_data, exp_d);
            chk("rnd_stb_drop", 32'(O_slv_stb), 32'h0);
            last_data = exp_d;
            I_slv_ack = 4'($urandom);
            step();
            chk("rnd_ack_end", 32'(O_ack), 32'h0);
            I_slv_ack = 0;
        end

`ifdef BUS_DEMUX32X4_TIMEOUT_EN
        // Timeout after eight ACTIVE cycles with no ack
        I_stb = 1; I_addr = 32'h0000_0000;
        step();
        I_stb = 0;
        for (int i = 1; i < 8; i++) begin
            step();
            chk("to_wait", 32'(O_ack), 32'h0);
        end
        step();
        chk("to_ack", 32'(O_ack), 32'h1);
        chk("to_err", 32'(O_err), 32'h1);
        chk("to_data", O_data, 32'h0);
        chk("to_stb", 32'(O_slv_stb), 32'h0);
        step();
        chk("to_ack_end", 32'(O_ack), 32'h0);

        // Ack on the expiry cycle wins
        I_stb = 1;
        step();
        I_stb = 0;
        for (int i = 1; i < 8; i++) begin
            step();
            chk("to2_wait", 32'(O_ack), 32'h0);
        end
        I_slv_ack = 4'b0001; sd[0] = 32'h7777_8888;
        step();
        chk("to2_ack", 32'(O_ack), 32'h1);
        chk("to2_err", 32'(O_err), 32'h0);
        chk("to2_data", O_data, 32'h7777_8888);
        I_slv_ack = 0;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
